// File: rtl/mem_stall_ctrl.sv
// Data-memory access sequencer and hazard controller for the 5-stage MIPS core.
// Freezes the pipeline while a MEM-stage access is outstanding and inserts load-use bubbles.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] RD,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushE,
    output logic        FlushW,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   ERR_DATA = 32'hDEADBEEF;

    state_t        state_reg, state_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rd_reg, rd_next;
    logic          err_reg, err_next;

    logic acc;
    logic mstall;
    logic lu;

    assign acc    = MemReadM | MemWriteM;
    assign mstall = ((state_reg == IDLE) & acc) | (state_reg == WAIT);
    assign lu     = MemtoRegE & (WriteRegE != 5'd0) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rd_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
            err_reg   <= err_next;
        end
    end

    // A ready response in the last allowed WAIT cycle wins over the timeout.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (acc) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_next = DONE;
                    if (MemReadM) begin
                        rd_next = mem_rdata;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    if (MemReadM) begin
                        rd_next = ERR_DATA;
                    end
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory stall dominates; the load-use bubble is only seen once it releases.
    always_comb begin
        mem_req = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        if (!rst) begin
            if (mstall) begin
                mem_req = 1'b1;
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                FlushW  = 1'b1;
            end else if (lu) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
            end
        end
    end

    assign mem_we    = MemWriteM;
    assign mem_addr  = ALUOutM;
    assign mem_wdata = WriteDataM;
    assign RD        = rd_reg;
    assign mem_err   = err_reg;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: stimulus pushes per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, MemtoRegE, mem_ready;
    logic [31:0] ALUOutM, WriteDataM, mem_rdata;
    logic [4:0]  WriteRegE, RsD, RtD;
    logic        mem_req, mem_we, StallF, StallD, StallE, StallM, FlushE, FlushW, mem_err;
    logic [31:0] mem_addr, mem_wdata, RD;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .RsD(RsD), .RtD(RtD),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .RD(RD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
    );

    // Control bundle order: {req, we, StallF, StallD, StallE, StallM, FlushE, FlushW, mem_err}
    localparam logic [8:0] Z  = 9'b000000000;
    localparam logic [8:0] MR = 9'b101111010;
    localparam logic [8:0] MW = 9'b111111010;
    localparam logic [8:0] LU = 9'b001100100;
    localparam logic [8:0] ER = 9'b000000001;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    task automatic step(input logic [8:0] c, input logic [31:0] rd_e);
        exp_t e;
        e.ctl   = c;
        e.rd    = rd_e;
        e.addr  = ALUOutM;
        e.wdata = WriteDataM;
        e.id    = step_no;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {mem_req, (e.ctl[8] ? mem_we : 1'b0), StallF, StallD, StallE, StallM,
                       FlushE, FlushW, mem_err};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL step%0d ctl: got %b want %b", e.id, act, e.ctl);
                end
                checks++;
                if (RD !== e.rd) begin
                    errors++;
                    $display("FAIL step%0d RD: got %h want %h", e.id, RD, e.rd);
                end
                if (e.ctl[8]) begin
                    checks++;
                    if (mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                        errors++;
                        $display("FAIL step%0d addr/wdata: got %h/%h want %h/%h",
                                 e.id, mem_addr, mem_wdata, e.addr, e.wdata);
                    end
                end
                $display("step%0d ctl=%b RD=%h", e.id, act, RD);
            end
        end
    end

    initial begin : stim
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; MemtoRegE = 1'b0; mem_ready = 1'b0;
        ALUOutM = '0; WriteDataM = '0; mem_rdata = '0; WriteRegE = '0; RsD = '0; RtD = '0;
        @(posedge clk);
        #1;
        step(Z, 32'h0);
        rst = 1'b0;

        // Load, ready in first WAIT cycle
        MemReadM = 1'b1; ALUOutM = 32'h10;
        step(MR, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        step(MR, 32'h0);
        mem_ready = 1'b0;
        step(Z, 32'h12345678);
        MemReadM = 1'b0;
        step(Z, 32'h12345678);

        // Store, 4 WAIT cycles; ready lands on the last cycle before timeout
        MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'hA5A5A5A5;
        for (int i = 0; i < 4; i++) step(MW, 32'h12345678);
        mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
        step(MW, 32'h12345678);
        step(Z, 32'h12345678);
        MemWriteM = 1'b0;
        step(Z, 32'h12345678);
        mem_ready = 1'b0;

        // Load-use without memory access
        MemtoRegE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5; RtD = 5'd0;
        step(LU, 32'h12345678);
        RsD = 5'd1; RtD = 5'd5;
        step(LU, 32'h12345678);
        WriteRegE = 5'd0; RsD = 5'd0; RtD = 5'd0;
        step(Z, 32'h12345678);
        WriteRegE = 5'd5; RsD = 5'd6; RtD = 5'd7;
        step(Z, 32'h12345678);
        MemtoRegE = 1'b0; RsD = 5'd5;
        step(Z, 32'h12345678);

        // Load-use concurrent with a load in MEM
        MemtoRegE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3; RtD = 5'd0;
        MemReadM = 1'b1; ALUOutM = 32'h40;
        step(MR, 32'h12345678);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        step(MR, 32'h12345678);
        mem_ready = 1'b0;
        step(LU, 32'hCAFEF00D);
        MemReadM = 1'b0; MemtoRegE = 1'b0;
        step(Z, 32'hCAFEF00D);

        // Timeout on a load, then a back-to-back load
        MemReadM = 1'b1; ALUOutM = 32'h80;
        for (int i = 0; i < 5; i++) step(MR, 32'hCAFEF00D);
        step(ER, 32'hDEADBEEF);
        ALUOutM = 32'h84;
        step(MR | ER, 32'hDEADBEEF);
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        step(MR | ER, 32'hDEADBEEF);
        mem_ready = 1'b0;
        step(ER, 32'h11112222);
        MemReadM = 1'b0;
        step(ER, 32'h11112222);

        // Reset in the second WAIT cycle with a ready response and load-use in flight
        MemReadM = 1'b1; ALUOutM = 32'h90;
        step(MR | ER, 32'h11112222);
        step(MR | ER, 32'h11112222);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h33333333;
        MemtoRegE = 1'b1; WriteRegE = 5'd9; RsD = 5'd9;
        step(ER, 32'h11112222);
        rst = 1'b0; mem_ready = 1'b0; MemReadM = 1'b0; MemtoRegE = 1'b0;
        step(Z, 32'h0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Pipeline controller for the 5-stage MIPS core. It sequences data-memory accesses from the MEM stage over a request/ready handshake and freezes the pipeline while an access is outstanding. It also detects load-use hazards between EX and ID. It drives the stall and flush enables of the IF/ID, ID/EX and EX/MEM registers, plus a bubble into the MEM/WB register. It supplies the captured read data `RD` that MEM/WB latches.

## Interface
- `TIMEOUT`, default 255: max WAIT cycles before abort; 1..2^TW-1
- `TW`, default 8: timeout counter width
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `MemReadM` in 1: MEM-stage instruction is a load
- `MemWriteM` in 1: MEM-stage instruction is a store
- `ALUOutM` in 32: MEM-stage address
- `WriteDataM` in 32: MEM-stage store data
- `MemtoRegE` in 1: EX-stage instruction is a load
- `WriteRegE` in 5: EX-stage destination register
- `RsD`, `RtD` in 5 each: ID-stage source registers
- `mem_req` out 1: memory request
- `mem_we` out 1: request is a write
- `mem_addr` out 32: request address
- `mem_wdata` out 32: request write data
- `mem_ready` in 1: memory completes the request this cycle
- `mem_rdata` in 32: read data, valid with `mem_ready`
- `RD` out 32: registered load data for MEM/WB
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold PC, IF/ID, ID/EX and EX/MEM
- `FlushE` out 1: clear ID/EX control bits (bubble)
- `FlushW` out 1: clear MEM/WB control bits (RegWriteW, MemtoRegW, LinkW forced 0)
- `mem_err` out 1: sticky timeout flag

## Operation
- States: IDLE, WAIT, DONE. Registered state, `cnt` [TW-1:0], `RD`, `mem_err`.
- `acc` = MemReadM | MemWriteM.
- IDLE:
  - If `acc`: assert `mem_req`, go to WAIT, `cnt` <= 0.
  - Else: stay in IDLE.
- WAIT: assert `mem_req`.
  - If `mem_ready`: go to DONE. On a read, `RD` <= `mem_rdata`.
  - Else if `cnt` == TIMEOUT-1: `mem_err` <= 1, `RD` <= 32'hDEADBEEF (on reads), go to DONE.
  - Else: `cnt` <= `cnt`+1.
- DONE:
  - `mem_req`=0 and no memory stall, so the completed instruction advances into MEM/WB this cycle.
  - `acc` is ignored. Next state is IDLE unconditionally.
- `mem_we`=MemWriteM, `mem_addr`=ALUOutM, `mem_wdata`=WriteDataM; all are meaningful only while `mem_req`=1.
- `mstall` = (IDLE & `acc`) | WAIT. While `mstall`:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0.
- Load-use condition `lu` = MemtoRegE & (WriteRegE != 0) & (WriteRegE == RsD | WriteRegE == RtD).
- When `lu` & !`mstall`: StallF=StallD=1, FlushE=1; StallE=StallM=FlushW=0.
- `mstall` has priority over `lu`; the load-use stall is re-evaluated after the memory stall releases.
- `mem_err` clears only on `rst`.

## Timing
- Reset values (`rst` high at an edge): state=IDLE, `cnt`=0, `RD`=0, `mem_err`=0.
- While `rst`=1, all combinational outputs are forced 0: `mem_req`, stalls, flushes.
- Reset during WAIT drops `mem_req` in the same cycle and returns to IDLE next edge. Any in-flight `mem_ready` is ignored.
- Minimum access is 3 cycles in MEM: IDLE-detect, WAIT with `mem_ready`, DONE. Each extra wait cycle adds one.
- Pipeline stall is asserted for (wait cycles + 1) cycles and released in DONE.
- `RD` is valid from the DONE cycle onward and is held until the next read completes. Writes leave `RD` unchanged.
- Timeout: with no `mem_ready`, DONE is entered after exactly TIMEOUT WAIT cycles.
- Back-to-back accesses: DONE→IDLE, then the next access is detected in IDLE. There is exactly one unstalled cycle between accesses.
- `mem_ready` is ignored in IDLE and DONE.

## Test plan
- Reset, then load at 0x10 with `mem_ready` in the first WAIT cycle returning 0x12345678 → `mem_req` high for 2 cycles; StallF..M and FlushW high for 2 cycles; RD=0x12345678 in DONE; stalls 0 in DONE.
- Store to 0x20 with data 0xA5A5A5A5 and 4 wait cycles → `mem_we`=1, addr and data stable for all 5 request cycles; RD unchanged; stall asserted for 5 cycles.
- TIMEOUT=4 with `mem_ready` never asserted → DONE after 4 WAIT cycles; `mem_err`=1 and stays 1; RD=0xDEADBEEF.
- Load-use: MemtoRegE=1, WriteRegE=5, RsD=5, no MEM access → StallF=StallD=FlushE=1, StallE=StallM=0. Repeat with WriteRegE=0 → all 0.
- Load-use concurrent with MEM access → FlushE=0 and StallE=1 during the memory stall; load-use response appears in DONE if the condition still holds.
- `rst` asserted in the 2nd WAIT cycle → `mem_req`=0 immediately; IDLE next cycle; RD=0, `mem_err`=0.
